// File: rtl/segment_7_pkg.sv
// rtl/segment_7_pkg.sv - shared 7-segment pattern constants for encoder and scan decoder
package segment_7_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   // All segments off
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Digits on the multiplexed bus
   localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/segment_7_pattern_decode.sv
// rtl/segment_7_pattern_decode.sv - combinational segment pattern to hex nibble decoder
module segment_7_pattern_decode
   import segment_7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       valid
);

   // Map each legal glyph back to its nibble; everything else, blank included, is undecodable
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b1;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: valid  = 1'b0;
         default:   valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/segment_7_scan_decoder.sv
// rtl/segment_7_scan_decoder.sv - recovers a 16-bit hex value from a scanned active-low 4-digit display bus
module segment_7_scan_decoder
   import segment_7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic [3:0]  digit_seen,
   output logic [3:0]  err
);

   localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

   logic [6:0]       s_seg;
   logic [3:0]       s_an;
   logic [6:0]       p_seg;
   logic [3:0]       p_an;
   logic [7:0]       cnt;
   logic [3:0][3:0]  digit_buf;

   logic [2:0]       zero_count;
   logic [1:0]       idx;
   logic             sample_valid;
   logic             same_sample;
   logic [7:0]       cnt_next;
   logic             accept;
   logic             good_accept;
   logic             bad_accept;
   logic [3:0]       seen_next;
   logic [3:0][3:0]  merged;
   logic             frame_done;
   logic [3:0]       nibble;
   logic             nibble_valid;

   segment_7_pattern_decode u_decode (
      .seg    (s_seg),
      .nibble (nibble),
      .valid  (nibble_valid)
   );

   // Find the single enabled digit; anything other than exactly one low anode is not a usable sample
   always_comb begin
      zero_count = 3'd0;
      idx        = 2'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!s_an[i]) begin
            zero_count = zero_count + 3'd1;
            idx        = 2'(i);
         end
      end
      sample_valid = (zero_count == 3'd1);
   end

   // Stability counting and the single accept per stable run, plus frame assembly
   always_comb begin
      same_sample = ({s_an, s_seg} == {p_an, p_seg});
      if (!sample_valid)
         cnt_next = 8'd0;
      else if (!same_sample)
         cnt_next = 8'd1;
      else if (cnt == STABLE_CNT)
         cnt_next = cnt;
      else
         cnt_next = cnt + 8'd1;

      // cnt saturates, so only the transition into STABLE_CNT is an accept
      accept      = sample_valid && (cnt != STABLE_CNT) && (cnt_next == STABLE_CNT);
      good_accept = accept && nibble_valid;
      bad_accept  = accept && !nibble_valid;

      seen_next = digit_seen;
      merged    = digit_buf;
      if (good_accept) begin
         seen_next[idx] = 1'b1;
         merged[idx]    = nibble;
      end
      frame_done = good_accept && (seen_next == 4'hF);
   end

   // Input register, sample history, digit collection and frame publication
   always_ff @(posedge clk) begin
      if (reset) begin
         s_seg       <= SEG_BLANK;
         s_an        <= 4'hF;
         p_seg       <= SEG_BLANK;
         p_an        <= 4'hF;
         cnt         <= 8'd0;
         digit_buf   <= '0;
         digit_seen  <= 4'h0;
         err         <= 4'h0;
         value       <= 16'h0000;
         frame_valid <= 1'b0;
      end else begin
         s_seg       <= seg;
         s_an        <= an;
         p_seg       <= s_seg;
         p_an        <= s_an;
         cnt         <= cnt_next;
         frame_valid <= frame_done;
         if (good_accept)
            digit_buf <= merged;
         digit_seen <= frame_done ? 4'h0 : seen_next;
         if (bad_accept)
            err[idx] <= 1'b1;
         if (frame_done)
            value <= merged;
      end
   end

endmodule

// File: tb/tb_segment_7_scan_decoder.sv
// tb/tb_segment_7_scan_decoder.sv - directed self-checking bench for segment_7_scan_decoder
module tb_segment_7_scan_decoder;
   import segment_7_pkg::*;

   logic        clk;
   logic        reset;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  digit_seen;
   logic [3:0]  err;

   int n_pass;
   int n_total;
   int frames;
   int f0;

   segment_7_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .seg         (seg),
      .an          (an),
      .value       (value),
      .frame_valid (frame_valid),
      .digit_seen  (digit_seen),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count frame_valid pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (!reset && frame_valid)
         frames = frames + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Present one pattern on the pins for n cycles; inputs change on the falling edge
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic blank(input int n);
      hold(4'hF, SEG_BLANK, n);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      frames  = 0;
      reset   = 1'b1;
      an      = 4'hF;
      seg     = SEG_BLANK;

      // Reset with random bus activity
      repeat (3) begin
         an  = 4'($urandom);
         seg = 7'($urandom);
         @(negedge clk);
      end
      check("reset_value", value, 16'h0000);
      check("reset_fv", {15'd0, frame_valid}, 16'h0000);
      check("reset_seen", {12'd0, digit_seen}, 16'h0000);
      check("reset_err", {12'd0, err}, 16'h0000);
      reset = 1'b0;
      blank(3);

      // Full frame 1234
      f0 = frames;
      hold(4'b1110, SEG_4, 8);
      hold(4'b1101, SEG_3, 8);
      hold(4'b1011, SEG_2, 8);
      hold(4'b0111, SEG_1, 8);
      blank(4);
      check("full_frames", 16'(frames - f0), 16'd1);
      check("full_value", value, 16'h1234);
      check("full_seen", {12'd0, digit_seen}, 16'h0000);
      check("full_err", {12'd0, err}, 16'h0000);

      // Ghost filter: 3-cycle glitch on digit 0 is ignored, a 4-cycle hold is accepted
      f0 = frames;
      hold(4'b1101, SEG_5, 8);
      hold(4'b1110, SEG_8, 3);
      hold(4'b1011, SEG_2, 8);
      blank(3);
      check("ghost_seen", {12'd0, digit_seen}, 16'h0006);
      hold(4'b1110, SEG_8, 4);
      blank(3);
      check("ghost_hold4", {12'd0, digit_seen}, 16'h0007);
      hold(4'b0111, SEG_7, 6);
      blank(3);
      check("ghost_value", value, 16'h7258);
      check("ghost_frames", 16'(frames - f0), 16'd1);

      // Undecodable pattern on digit 2 sets err and blocks the frame
      f0 = frames;
      hold(4'b1011, 7'b1111111, 6);
      blank(3);
      check("inv_err", {12'd0, err}, 16'h0004);
      check("inv_seen", {12'd0, digit_seen}, 16'h0000);
      hold(4'b1110, SEG_A, 6);
      blank(2);
      hold(4'b1101, SEG_B, 6);
      blank(2);
      hold(4'b0111, SEG_C, 6);
      blank(3);
      check("inv_seen3", {12'd0, digit_seen}, 16'h000B);
      check("inv_noframe", 16'(frames - f0), 16'd0);
      check("inv_value_hold", value, 16'h7258);
      hold(4'b1011, SEG_D, 6);
      blank(3);
      check("inv_value", value, 16'hCDBA);
      check("inv_frames", 16'(frames - f0), 16'd1);
      check("inv_err_sticky", {12'd0, err}, 16'h0004);

      // Overwrite digit 0, blanks between digits, 50-cycle hold on the last digit
      f0 = frames;
      hold(4'b1110, SEG_5, 6);
      blank(2);
      hold(4'b1110, SEG_A, 6);
      blank(3);
      check("ovw_seen", {12'd0, digit_seen}, 16'h0001);
      hold(4'b1101, SEG_0, 6);
      blank(3);
      hold(4'b1011, SEG_E, 6);
      blank(3);
      check("blank_seen", {12'd0, digit_seen}, 16'h0007);
      check("blank_err", {12'd0, err}, 16'h0004);
      hold(4'b0111, SEG_F, 50);
      check("long_seen", {12'd0, digit_seen}, 16'h0000);
      blank(3);
      check("ovw_value", value, 16'hFE0A);
      check("ovw_nibble", {12'd0, value[3:0]}, 16'h000A);
      check("long_frames", 16'(frames - f0), 16'd1);

      // Reset mid-frame discards collected digits
      hold(4'b1110, SEG_1, 6);
      hold(4'b1101, SEG_2, 6);
      hold(4'b1011, SEG_3, 6);
      blank(3);
      check("mid_seen", {12'd0, digit_seen}, 16'h0007);
      reset = 1'b1;
      blank(1);
      reset = 1'b0;
      check("mid_rst_seen", {12'd0, digit_seen}, 16'h0000);
      check("mid_rst_err", {12'd0, err}, 16'h0000);
      check("mid_rst_value", value, 16'h0000);
      blank(2);
      f0 = frames;
      hold(4'b1110, SEG_9, 6);
      hold(4'b1101, SEG_8, 6);
      hold(4'b1011, SEG_7, 6);
      hold(4'b0111, SEG_6, 6);
      blank(3);
      check("mid_value", value, 16'h6789);
      check("mid_frames", 16'(frames - f0), 16'd1);
      check("mid_seen_end", {12'd0, digit_seen}, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/segment_7_scan_decoder.md
# segment_7_scan_decoder

Receive-side counterpart of the binary-to-7-segment encoder. It watches a multiplexed 4-digit, active-low segment/anode bus and recovers the displayed hex value. Each digit pattern is decoded back to a nibble, and the decoder filters ghosting by requiring each pattern to hold steady before it is accepted. A full 16-bit value is presented once every digit has been refreshed. Used as an on-chip display monitor and as a self-check for the display path.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical registered samples needed to accept a digit; legal range 2..255.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- seg  in  7  active-low segment lines, {g,f,e,d,c,b,a}.
- an  in  4  active-low digit enables; an[0] is the least-significant digit.
- value  out  16  last complete frame, digit 3 in [15:12] down to digit 0 in [3:0].
- frame_valid  out  1  one-cycle pulse when value updates.
- digit_seen  out  4  digits accepted since the last frame.
- err  out  4  sticky per-digit flag: an undecodable pattern was accepted on that digit.

## Operation
- **Input stage.** seg and an are registered once into s_seg and s_an. All logic below works on the registered copy.
- **Valid sample.** A sample is valid only if s_an has exactly one bit low. Blank (4'hF) or multiple low bits is invalid.
- **Stability counter cnt** (8-bit, saturating at STABLE_CYCLES).
  - Valid sample identical to the previous cycle's {s_an, s_seg}: cnt increments.
  - Valid sample that differs from the previous cycle: cnt is set to 1.
  - Invalid sample: cnt is set to 0.
- **Accept event.** Occurs on the cycle cnt becomes exactly STABLE_CYCLES, so there is one event per stable run. The digit index idx is the position of the low bit of s_an.
  - Decodable pattern: digit_buf[idx] <= nibble; digit_seen[idx] <= 1.
  - Undecodable pattern: err[idx] <= 1; digit_buf and digit_seen are unchanged.
- **Decode table** (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Anything else is undecodable, including all-off 1111111.
- **Frame completion.** When an accept makes the next value of digit_seen equal 4'hF:
  - value <= digit_buf with the new nibble merged in;
  - frame_valid = 1 for that one cycle;
  - digit_seen <= 4'h0.
- **Re-accepting a digit before the frame completes.** The nibble is overwritten with the newest value; digit_seen is unchanged.
- **err behaviour.** Cleared only by reset. A later good accept on the same digit does not clear it.
- **State machine.** No explicit FSM. State is cnt, the previous sample, digit_buf[4], digit_seen and err.

## Timing
- **Reset values** (edge with reset=1):
  - value=16'h0000, frame_valid=0, digit_seen=4'h0, err=4'h0;
  - cnt=0, s_an=4'hF, s_seg=7'h7F, digit_buf all 0.
- **Reset mid-frame.** Partially collected digits are discarded.
- **Acceptance latency.** If a pattern is first presented on the pins in cycle N and held, it is registered in N+1 and accepted at the edge ending cycle N+STABLE_CYCLES. digit_seen and err reflect the accept in cycle N+STABLE_CYCLES+1.
- **Frame latency.** frame_valid and the new value appear in cycle N+STABLE_CYCLES+1, where N refers to the final digit's first presentation. value holds until the next frame.
- **Short runs.** A run shorter than STABLE_CYCLES is never accepted.
- **Long runs.** A run longer than STABLE_CYCLES is accepted exactly once.
- **Back-to-back frames.** The first digit of the next frame may be accepted in the cycle immediately after frame_valid.
- **Anode change, same seg.** Treated as a differing sample: cnt is set to 1.

## Structure
- Shared package segment_7_pkg holds:
  - the 16 pattern constants (SEG_0..SEG_F, active-low);
  - SEG_BLANK = 7'h7F;
  - the digit count constant NUM_DIGITS = 4.
- The encoder uses the same constants.
- Sub-module segment_7_pattern_decode: combinational; seg[6:0] in; nibble[3:0] and valid out.
- The top level contains the input register, stability counter, digit buffer and frame logic.

## Test plan
All scenarios use STABLE_CYCLES=4.
- **Reset.** Hold reset 3 cycles with random inputs -> value=0, frame_valid=0, digit_seen=0, err=0.
- **Full frame.** Present 8 cycles per digit: an=1110/seg=SEG_4, then 1101/SEG_3, 1011/SEG_2, 0111/SEG_1 -> exactly one frame_valid pulse, value=16'h1234, digit_seen returns to 0.
- **Ghost filter.** 3-cycle glitch an=1110/seg=SEG_8 between valid digits -> digit 0 not updated and no accept. A 4-cycle hold -> accepted.
- **Invalid pattern.** Hold an=1011, seg=7'b1111111 for 6 cycles -> err=4'b0100, digit_seen[2] stays 0. Completing the other digits yields no frame until digit 2 gets a valid pattern.
- **Overwrite, blanking, long hold.**
  - Digit 0 accepted as 5, then as A, before the frame completes -> value[3:0]=A.
  - Blank an=1111 inserted between digits -> no accept, no error.
  - A 50-cycle hold -> only one accept.
- **Reset mid-frame.** Accept 3 digits, assert reset 1 cycle, then send a full frame 9,8,7,6 -> value=16'h6789 with no residue from before reset.
